// File: rtl/lcd_msg_seq.sv
// ============================================================================
// Module   : lcd_msg_seq
// Brief    : Registered door-lock LCD text generator with countdown digits,
//            WARNING blink and update/ack handshake toward the LCD driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_msg_seq #(
  parameter int COLS      = 16,
  parameter int BLINK_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        state_i,
  input  logic              eval_i,
  input  logic              success_i,
  input  logic [7:0]        wait_sec_i,
  input  logic              upd_ack_i,
  output logic [8*COLS-1:0] lcd_h0_o,
  output logic [8*COLS-1:0] lcd_h1_o,
  output logic              upd_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSE   = 3'd3,
    ST_NEW     = 3'd4,
    ST_EXIT    = 3'd5,
    ST_WRONG   = 3'd6,
    ST_WARNING = 3'd7
  } lock_state_e;

  localparam int              CW        = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CW-1:0]   C_CNT_MAX = CW'(BLINK_CYC - 1);
  localparam logic [127:0]    C_IDLE0   = "Enter password  ";
  localparam logic [127:0]    C_IDLE1   = "    to open     ";

  lock_state_e       st;
  logic [6:0]        sat;
  logic [6:0]        tens;
  logic [6:0]        ones;
  logic [7:0]        tens_a;
  logic [7:0]        ones_a;
  logic [127:0]      line0;
  logic [127:0]      line1;
  logic [8*COLS-1:0] lcd_h0_d, lcd_h0_q;
  logic [8*COLS-1:0] lcd_h1_d, lcd_h1_q;
  logic              upd_d, upd_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic              hidden_d, hidden_q;
  logic              diff;

  assign st     = lock_state_e'(state_i);
  assign sat    = (wait_sec_i > 8'd99) ? 7'd99 : wait_sec_i[6:0];
  assign tens   = sat / 7'd10;
  assign ones   = sat % 7'd10;
  assign tens_a = 8'h30 + {1'b0, tens};
  assign ones_a = 8'h30 + {1'b0, ones};

  always_comb begin
    line0 = C_IDLE0;
    line1 = C_IDLE1;
    case (st)
      ST_IDLE: begin
        line0 = C_IDLE0;
        line1 = C_IDLE1;
      end
      ST_WAIT: begin
        line0 = "Correct, press #";
        line1 = "open or 3* new  ";
      end
      ST_OPEN: begin
        line0 = eval_i ? "Open over 30s   " : "Door opening    ";
        line1 = eval_i ? "Please press #,*" : "To close press #";
      end
      ST_CLOSE: begin
        line0 = {"Door close in ", tens_a, ones_a};
        line1 = "To open press # ";
      end
      ST_NEW: begin
        line0 = "Enter new pass  ";
        line1 = "Save press # 3s ";
      end
      ST_EXIT: begin
        line0 = success_i ? "Successfully sav" : "Fail to save new";
        line1 = success_i ? "e new pass, EXIT" : "pass, EXIT      ";
      end
      ST_WRONG: begin
        line0 = "Wrong pass!     ";
        line1 = {"Wait after: ", tens_a, ones_a, "s "};
      end
      ST_WARNING: begin
        line0 = hidden_q ? {16{8'h20}} : "Wrong pass!     ";
        line1 = "Try again       ";
      end
      default: begin
        line0 = C_IDLE0;
        line1 = C_IDLE1;
      end
    endcase
  end

  // Text occupies the leftmost 16 characters; any extra columns stay blank.
  always_comb begin
    lcd_h0_d = {COLS{8'h20}};
    lcd_h1_d = {COLS{8'h20}};
    lcd_h0_d[8*COLS-1 -: 128] = line0;
    lcd_h1_d[8*COLS-1 -: 128] = line1;
  end

  assign diff = (lcd_h0_d != lcd_h0_q) || (lcd_h1_d != lcd_h1_q);

  // A fresh difference beats a concurrent ack so the driver never misses a redraw.
  always_comb begin
    upd_d = upd_q;
    if (diff) begin
      upd_d = 1'b1;
    end else if (upd_q && upd_ack_i) begin
      upd_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d    = '0;
    hidden_d = 1'b0;
    if (st == ST_WARNING) begin
      if (cnt_q == C_CNT_MAX) begin
        cnt_d    = '0;
        hidden_d = ~hidden_q;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        hidden_d = hidden_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_h0_q <= {COLS{8'h20}};
      lcd_h1_q <= {COLS{8'h20}};
      lcd_h0_q[8*COLS-1 -: 128] <= C_IDLE0;
      lcd_h1_q[8*COLS-1 -: 128] <= C_IDLE1;
      upd_q    <= 1'b1;
      cnt_q    <= '0;
      hidden_q <= 1'b0;
    end else begin
      if (diff) begin
        lcd_h0_q <= lcd_h0_d;
        lcd_h1_q <= lcd_h1_d;
      end
      upd_q    <= upd_d;
      cnt_q    <= cnt_d;
      hidden_q <= hidden_d;
    end
  end

  assign lcd_h0_o = lcd_h0_q;
  assign lcd_h1_o = lcd_h1_q;
  assign upd_o    = upd_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_msg_seq.sv
// ============================================================================
// Module   : tb_lcd_msg_seq
// Brief    : Directed self-checking bench for lcd_msg_seq (16 and 20 columns).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_msg_seq;

  logic         clk;
  logic         rst;
  logic [2:0]   state;
  logic         eval;
  logic         success;
  logic [7:0]   wait_sec;
  logic         upd_ack;
  logic [127:0] h0, h1;
  logic         upd;
  logic [159:0] h0w, h1w;
  logic         updw;

  int n_vec;
  int n_bad;

  lcd_msg_seq #(.COLS(16), .BLINK_CYC(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .state_i    (state),
    .eval_i     (eval),
    .success_i  (success),
    .wait_sec_i (wait_sec),
    .upd_ack_i  (upd_ack),
    .lcd_h0_o   (h0),
    .lcd_h1_o   (h1),
    .upd_o      (upd)
  );

  lcd_msg_seq #(.COLS(20), .BLINK_CYC(4)) u_dut_w (
    .clk        (clk),
    .rst        (rst),
    .state_i    (state),
    .eval_i     (eval),
    .success_i  (success),
    .wait_sec_i (wait_sec),
    .upd_ack_i  (upd_ack),
    .lcd_h0_o   (h0w),
    .lcd_h1_o   (h1w),
    .upd_o      (updw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_lines(input string tag, input logic [127:0] e0,
                           input logic [127:0] e1, input logic eu);
    chk({tag, " h0"}, {32'd0, h0}, {32'd0, e0});
    chk({tag, " h1"}, {32'd0, h1}, {32'd0, e1});
    chk({tag, " upd"}, {159'd0, upd}, {159'd0, eu});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] vis;
  logic [127:0] blank;

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    vis      = "Wrong pass!     ";
    blank    = {16{8'h20}};
    rst      = 1'b1;
    state    = 3'd0;
    eval     = 1'b0;
    success  = 1'b0;
    wait_sec = 8'd0;
    upd_ack  = 1'b0;

    // 1: reset state and first ack
    step();
    rst = 1'b0;
    chk_lines("reset", "Enter password  ", "    to open     ", 1'b1);
    chk("reset wide h0", h0w, {"Enter password  ", 32'h20202020});
    chk("reset wide h1", h1w, {"    to open     ", 32'h20202020});
    upd_ack = 1'b1;
    step();
    chk("ack clears upd", {159'd0, upd}, 160'd0);
    upd_ack = 1'b0;

    // 2: IDLE -> WAIT, no ack keeps upd high
    state = 3'd1;
    step();
    chk_lines("wait", "Correct, press #", "open or 3* new  ", 1'b1);
    step();
    step();
    chk_lines("wait hold", "Correct, press #", "open or 3* new  ", 1'b1);
    upd_ack = 1'b1;
    step();
    chk("wait ack", {159'd0, upd}, 160'd0);
    upd_ack = 1'b0;

    // 3: CLOSE countdown with saturation
    state = 3'd3;
    wait_sec = 8'd10;
    step();
    chk_lines("close 10", "Door close in 10", "To open press # ", 1'b1);
    upd_ack = 1'b1;
    step();
    chk("close ack", {159'd0, upd}, 160'd0);
    upd_ack = 1'b0;
    wait_sec = 8'd9;
    step();
    chk_lines("close 09", "Door close in 09", "To open press # ", 1'b1);
    upd_ack = 1'b1;
    step();
    upd_ack = 1'b0;
    wait_sec = 8'd150;
    step();
    chk_lines("close 99", "Door close in 99", "To open press # ", 1'b1);
    upd_ack = 1'b1;
    step();
    chk("close99 ack", {159'd0, upd}, 160'd0);

    // 4: WARNING blink, ack held high
    state = 3'd7;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_lines($sformatf("warn c%0d", i),
                ((i >= 5) && (i <= 8)) ? blank : vis,
                "Try again       ",
                (i == 1) || (i == 5) || (i == 9));
    end

    // 5: ack coincides with a new text
    upd_ack = 1'b0;
    state = 3'd1;
    step();
    chk("to wait upd", {159'd0, upd}, {159'd0, 1'b1});
    state = 3'd4;
    upd_ack = 1'b1;
    step();
    chk_lines("new wins", "Enter new pass  ", "Save press # 3s ", 1'b1);
    step();
    chk("new ack", {159'd0, upd}, 160'd0);

    // remaining texts
    state = 3'd2; eval = 1'b0;
    step();
    chk_lines("open", "Door opening    ", "To close press #", 1'b1);
    eval = 1'b1;
    step();
    chk_lines("open30", "Open over 30s   ", "Please press #,*", 1'b1);
    state = 3'd5; success = 1'b1;
    step();
    chk_lines("exit ok", "Successfully sav", "e new pass, EXIT", 1'b1);
    success = 1'b0;
    step();
    chk_lines("exit fail", "Fail to save new", "pass, EXIT      ", 1'b1);
    state = 3'd6; wait_sec = 8'd5;
    step();
    chk_lines("wrong 05", "Wrong pass!     ", "Wait after: 05s ", 1'b1);
    wait_sec = 8'd99;
    step();
    chk_lines("wrong 99", "Wrong pass!     ", "Wait after: 99s ", 1'b1);

    // 6: reset during hidden phase, then re-entry starts visible
    state = 3'd7;
    for (int i = 0; i < 5; i++) step();
    chk_lines("pre-rst blank", blank, "Try again       ", 1'b1);
    chk("pre-rst wide h0", h0w, {160{1'b0}} | {blank, 32'h20202020});
    rst = 1'b1;
    step();
    rst = 1'b0;
    upd_ack = 1'b0;
    chk_lines("mid rst", "Enter password  ", "    to open     ", 1'b1);
    step();
    chk_lines("rst reentry", vis, "Try again       ", 1'b1);
    chk("wide h0", h0w, {"Wrong pass!     ", 32'h20202020});
    chk("wide h1", h1w, {"Try again       ", 32'h20202020});
    chk("wide upd", {159'd0, updw}, {159'd0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
